issue_sched: RTL
================

Name: issue_sched

Overview:
Issue controller between the decode stage and the register-read/execute stage of the ARM-style core pipeline. It accepts one decoded instruction at a time and holds it while any source register or the CPSR flags have a write still in flight (scoreboard). It then sequences the operand reads onto the 2-read-port register file, taking an extra cycle when three distinct sources are needed, and hands the instruction to execute with a valid/ready handshake.

Parameters:
NREG, 16, number of architectural registers tracked by the scoreboard (index width fixed at 4).
CNT_W, 16, width of the optional performance counters.

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
dec_valid  input  1  decode offers an instruction
dec_ready  output  1  scheduler can accept an instruction
dec_rn / dec_rm / dec_rs  input  4 each  source register indices
dec_rn_use / dec_rm_use / dec_rs_use  input  1 each  the matching source is actually read
dec_rd  input  4  destination register
dec_rd_wr  input  1  instruction writes dec_rd
dec_s_cpsr  input  1  instruction writes the CPSR flags
dec_cond_use  input  1  condition field is not AL, so the flags are read
rf_ra1, rf_ra2  output  4 each  register-file read addresses
rf_re1, rf_re2  output  1 each  read-port enables
rf_sel  output  2  operand slot being loaded: 0 = first pair, 1 = third source
iss_valid  output  1  instruction ready for execute
iss_ready  input  1  execute accepts
wb_valid  input  1  writeback retires a register write
wb_rd  input  4  register retired
wb_flags  input  1  writeback retires a flag write
sb_busy  output  16  scoreboard pending bits
flag_busy  output  1  flag write pending
sb_err  output  1  sticky: writeback to a non-pending register
stall_cnt, issue_cnt  output  CNT_W each  performance counters

Behaviour:
- Reset (asynchronous, rst_n = 0): state IDLE; sb_busy = 0, flag_busy = 0, sb_err = 0, counters = 0. All other outputs are 0, including dec_ready during reset. Reset mid-operation discards the captured instruction.
- State IDLE: dec_ready = 1. On dec_valid & dec_ready, all dec_* fields are registered and the state moves to CHECK.
- State CHECK: hazard is raised if any of these holds:
  - a used source has its busy bit set;
  - dec_rd_wr is set and busy[rd] is set (WAW);
  - (cond_use | s_cpsr) is set and flag_busy is set.
  - The check uses busy bits already masked by a same-cycle wb_valid/wb_rd (and wb_flags for the flags). A writeback therefore releases a stall in the same cycle.
  - The state stays in CHECK while the hazard holds; stall_cnt increments in each such cycle.
- Source coalescing: used sources are taken in the order rn, rm, rs. Duplicate indices count once. N = number of distinct used sources (0 to 3).
- Leaving CHECK when there is no hazard: N = 0 goes to ISSUE; N = 1 or 2 goes to RD_A; N = 3 goes to RD_A and then RD_B.
- State RD_A: rf_ra1/rf_ra2 carry the first and second distinct sources. rf_re1 is set, and rf_re2 is set only if N ≥ 2. rf_sel = 0.
- State RD_B: rf_ra1 carries the third source, rf_re1 = 1, rf_sel = 1.
- State ISSUE: iss_valid = 1 and is held until iss_ready. On the handshake:
  - busy[rd] is set if rd_wr;
  - flag_busy is set if s_cpsr;
  - issue_cnt increments;
  - the state returns to IDLE.
- Minimum latency: accept at cycle 0, CHECK at cycle 1, RD_A at cycle 2, iss_valid at cycle 3. Three sources add 1 cycle. Throughput is at most one instruction per 4 cycles.
- Writeback: wb_valid clears busy[wb_rd]. If busy[wb_rd] was already 0, sb_err is set and the scoreboard is unchanged. wb_flags clears flag_busy under the same error rule.
- Simultaneous set and clear of the same bit (issue handshake plus writeback): set wins.
- r15 is scoreboarded like any other register.
- Counters saturate at all-ones.

Optional Feature:
SCHED_PERF_EN
- Defined: stall_cnt and issue_cnt are implemented as described above.
- Undefined: both counters are held at 0 and no counter logic is generated. The ports remain present.

Test Plan:
1. Reset, then issue ADD r11,r13,#0 (rn=13, rd_wr=11) with iss_ready=1 → iss_valid at cycle 3, rf_ra1=13, rf_re2=0, sb_busy=0x0800.
2. With r3 busy, issue ADD r3,r2,r3 → stays in CHECK, stall_cnt increments each cycle. wb_valid with wb_rd=3 on stall cycle 2 → RD_A on the next cycle with ra1=2, ra2=3.
3. Issue an instruction with rn=rm=rs=4 → N=1, a single RD_A cycle. Issue one with rn=1, rm=2, rs=5 → RD_A(1,2), then RD_B(5), iss_valid at cycle 4.
4. flag_busy=1, issue a conditional instruction (cond_use=1) → stalls until wb_flags=1. Issue with iss_ready held 0 for 3 cycles → iss_valid held for those cycles and busy is set only on the handshake.
5. Issue handshake setting r7 while wb_valid retires r7 in the same cycle → busy[7]=1 and sb_err=0. wb_valid with wb_rd=9 while not busy → sb_err=1 until reset.
6. Drop rst_n in RD_B → all outputs 0 immediately. After release, dec_ready=1 and sb_busy=0.

Source files
------------

// File: rtl/issue_sched.sv
// Issue scheduler: scoreboard hazard check, 2-port register-read sequencing, issue handshake.
// Optional performance counters are built only when SCHED_PERF_EN is defined.
module issue_sched #(
   parameter int unsigned NREG  = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  logic [3:0]       dec_rn,
   input  logic [3:0]       dec_rm,
   input  logic [3:0]       dec_rs,
   input  logic             dec_rn_use,
   input  logic             dec_rm_use,
   input  logic             dec_rs_use,
   input  logic [3:0]       dec_rd,
   input  logic             dec_rd_wr,
   input  logic             dec_s_cpsr,
   input  logic             dec_cond_use,
   output logic [3:0]       rf_ra1,
   output logic [3:0]       rf_ra2,
   output logic             rf_re1,
   output logic             rf_re2,
   output logic [1:0]       rf_sel,
   output logic             iss_valid,
   input  logic             iss_ready,
   input  logic             wb_valid,
   input  logic [3:0]       wb_rd,
   input  logic             wb_flags,
   output logic [NREG-1:0]  sb_busy,
   output logic             flag_busy,
   output logic             sb_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] issue_cnt
);

   typedef enum logic [2:0] {StIdle, StCheck, StRdA, StRdB, StIssue} state_e;

   state_e          state_q, state_d;
   logic [3:0]      rn_q, rm_q, rs_q, rd_q;
   logic            rn_use_q, rm_use_q, rs_use_q, rd_wr_q, s_cpsr_q, cond_use_q;
   logic [3:0]      src0, src1, src2;
   logic [1:0]      nsrc;
   logic [NREG-1:0] busy_q, busy_d, wb_mask, busy_eff;
   logic            flag_q, flag_d, flag_eff, err_q, err_d;
   logic            hazard, accept, issue_hs, set_rd, set_fl;

   // Distinct used sources in rn, rm, rs order.
   always_comb begin
      src0 = '0;
      src1 = '0;
      src2 = '0;
      nsrc = 2'd0;
      if (rn_use_q) begin
         src0 = rn_q;
         nsrc = 2'd1;
      end
      if (rm_use_q) begin
         if (nsrc == 2'd0) begin
            src0 = rm_q;
            nsrc = 2'd1;
         end else if (rm_q != src0) begin
            src1 = rm_q;
            nsrc = 2'd2;
         end
      end
      if (rs_use_q) begin
         if (nsrc == 2'd0) begin
            src0 = rs_q;
            nsrc = 2'd1;
         end else if (nsrc == 2'd1) begin
            if (rs_q != src0) begin
               src1 = rs_q;
               nsrc = 2'd2;
            end
         end else if (rs_q != src0 && rs_q != src1) begin
            src2 = rs_q;
            nsrc = 2'd3;
         end
      end
   end

   // Same-cycle writebacks are masked out so they release a stall immediately.
   assign wb_mask  = wb_valid ? (NREG'(1) << wb_rd) : '0;
   assign busy_eff = busy_q & ~wb_mask;
   assign flag_eff = flag_q & ~wb_flags;
   assign hazard   = (rn_use_q & busy_eff[rn_q]) | (rm_use_q & busy_eff[rm_q]) |
                     (rs_use_q & busy_eff[rs_q]) | (rd_wr_q & busy_eff[rd_q]) |
                     ((cond_use_q | s_cpsr_q) & flag_eff);

   assign accept   = dec_valid & dec_ready;
   assign issue_hs = (state_q == StIssue) & iss_ready;
   assign set_rd   = issue_hs & rd_wr_q;
   assign set_fl   = issue_hs & s_cpsr_q;

   always_comb begin
      state_d   = state_q;
      dec_ready = 1'b0;
      rf_ra1    = '0;
      rf_ra2    = '0;
      rf_re1    = 1'b0;
      rf_re2    = 1'b0;
      rf_sel    = 2'd0;
      iss_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            dec_ready = rst_n;
            if (dec_valid) state_d = StCheck;
         end
         StCheck: begin
            if (!hazard) state_d = (nsrc == 2'd0) ? StIssue : StRdA;
         end
         StRdA: begin
            rf_ra1  = src0;
            rf_ra2  = src1;
            rf_re1  = 1'b1;
            rf_re2  = (nsrc >= 2'd2);
            state_d = (nsrc == 2'd3) ? StRdB : StIssue;
         end
         StRdB: begin
            rf_ra1  = src2;
            rf_re1  = 1'b1;
            rf_sel  = 2'd1;
            state_d = StIssue;
         end
         StIssue: begin
            iss_valid = 1'b1;
            if (iss_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // A retire colliding with a same-cycle issue of that register is absorbed by the set.
   always_comb begin
      busy_d = busy_q;
      flag_d = flag_q;
      err_d  = err_q;
      if (wb_valid) begin
         if (busy_q[wb_rd]) busy_d[wb_rd] = 1'b0;
         else if (!(set_rd && rd_q == wb_rd)) err_d = 1'b1;
      end
      if (wb_flags) begin
         if (flag_q) flag_d = 1'b0;
         else if (!set_fl) err_d = 1'b1;
      end
      if (set_rd) busy_d[rd_q] = 1'b1;
      if (set_fl) flag_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         busy_q     <= '0;
         flag_q     <= 1'b0;
         err_q      <= 1'b0;
         rn_q       <= '0;
         rm_q       <= '0;
         rs_q       <= '0;
         rd_q       <= '0;
         rn_use_q   <= 1'b0;
         rm_use_q   <= 1'b0;
         rs_use_q   <= 1'b0;
         rd_wr_q    <= 1'b0;
         s_cpsr_q   <= 1'b0;
         cond_use_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         flag_q  <= flag_d;
         err_q   <= err_d;
         if (accept) begin
            rn_q       <= dec_rn;
            rm_q       <= dec_rm;
            rs_q       <= dec_rs;
            rd_q       <= dec_rd;
            rn_use_q   <= dec_rn_use;
            rm_use_q   <= dec_rm_use;
            rs_use_q   <= dec_rs_use;
            rd_wr_q    <= dec_rd_wr;
            s_cpsr_q   <= dec_s_cpsr;
            cond_use_q <= dec_cond_use;
         end
      end
   end

   assign sb_busy   = busy_q;
   assign flag_busy = flag_q;
   assign sb_err    = err_q;

`ifdef SCHED_PERF_EN
   logic [CNT_W-1:0] stall_q, issue_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         issue_q <= '0;
      end else begin
         if (state_q == StCheck && hazard && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (issue_hs && !(&issue_q)) issue_q <= issue_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign issue_cnt = issue_q;
`else
   assign stall_cnt = '0;
   assign issue_cnt = '0;
`endif

endmodule
